da_bit_slicer: RTL and testbench
================================

// Module: da_bit_slicer
// PURPOSE
//   Front end for the distributed-arithmetic (DA) core.
//   - Accepts TAPS parallel two's-complement words through a valid/ready handshake.
//   - Emits them as a bit-slice stream, one column per cycle, LSB first.
//   - Each slice is the TAPS-bit LUT address the DA core uses for one accumulate step.
//   - Flags the first slice (clear accumulator) and the sign-bit slice (subtract).
// PARAMETERS
//   TAPS   4  number of input words (= DA LUT address width)
//   WIDTH  4  bits per word (= slices per frame); WIDTH>=1
// PORTS
//   clk_80          in   1           system clock, all logic on rising edge
//   rst_80          in   1           synchronous reset, active-high
//   in_valid_80     in   1           in_data_80 holds a frame
//   in_ready_80     out  1           slicer can accept a frame this cycle
//   in_data_80      in   TAPS*WIDTH  word k = in_data_80[k*WIDTH +: WIDTH]
//   slice_valid_80  out  1           slice_80 is valid
//   slice_ready_80  in   1           downstream DA core consumes slice this cycle
//   slice_80        out  TAPS        slice_80[k] = bit b of word k
//   slice_first_80  out  1           b == 0 (LSB slice)
//   slice_last_80   out  1           b == WIDTH-1 (sign slice)
//   busy_80         out  1           frame in progress (state SHIFT)
// BEHAVIOUR
//   Reset
//   - rst_80 sampled high: state=IDLE, bit counter=0, shift regs=0.
//   - slice_valid/slice/first/last/busy=0 next cycle.
//   - in_ready_80=0 while rst_80 high.
//   - Reset mid-frame aborts it; no further slices of that frame.
//   FSM
//   - IDLE: in_ready=1, slice_valid=0.
//     - in_valid&in_ready: load TAPS shift regs, cnt=0, go to SHIFT.
//   - SHIFT: slice_valid=1; slice_80 = LSB column of shift regs.
//     - first=(cnt==0); last=(cnt==WIDTH-1).
//     - slice_ready=1 and not last: shift every word right 1, cnt++.
//     - slice_ready=1 and last: if in_valid, load next frame, cnt=0, stay SHIFT
//       (zero-bubble back-to-back); else go to IDLE.
//     - slice_ready=0: all regs and outputs hold, stable.
//   Handshake
//   - in_ready_80 = IDLE | (SHIFT & last & slice_ready_80). Combinational on
//     slice_ready_80 only.
//   - in_data_80 is sampled only on acceptance; changes while in_ready=0 are ignored.
//   Timing
//   - Frame accepted at edge N: first slice visible after edge N.
//   - Throughput: WIDTH cycles per frame with no stalls.
//   - Outputs are register-driven; no combinational path from in_data_80.
//   Arithmetic
//   - No arithmetic; bits passed unmodified.
//   - Sign handling belongs to the DA core via slice_last_80.
//   - WIDTH=1: first and last both asserted on the single slice.
// TESTING (TAPS=4, WIDTH=4)
//   1. Reset: rst_80=1 for 2 cycles with in_valid=1 -> in_ready=0, slice_valid=0,
//      slice=0; after release in_ready=1.
//   2. Single frame: in_data=16'h6F5B, slice_ready=1 -> slices 4'b0111,1101,1110,0101
//      on 4 consecutive cycles. first on slice 1, last on slice 4; then IDLE.
//   3. Back-to-back: 16'h6F5B then 16'hFFFF held valid -> 2nd frame accepted on
//      slice 4. Slices 1111 x4 follow with no bubble; first re-asserts.
//   4. Backpressure: slice_ready=0 for 3 cycles while slice 1101 shown -> 1101 and
//      flags held. Frame completes in 7 cycles; no slice lost or repeated.
//   5. Reset mid-frame after slice 2 -> slice_valid=0 next cycle. New frame 16'h0001
//      -> slices 0001,0000,0000,0000 starting with first=1.
//   6. Input churn: change in_data every cycle during SHIFT -> emitted slices match
//      the frame captured at acceptance only.

Source files
------------

// File: rtl/da_bit_slicer.sv
// Bit-slice front end for the distributed-arithmetic core: takes TAPS parallel words and
// streams one TAPS-bit LUT address per cycle, LSB column first, flagging first/sign slices.
module da_bit_slicer #(
  parameter int unsigned TAPS  = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk_80,
  input  logic                    rst_80,
  input  logic                    in_valid_80,
  output logic                    in_ready_80,
  input  logic [TAPS*WIDTH-1:0]   in_data_80,
  output logic                    slice_valid_80,
  input  logic                    slice_ready_80,
  output logic [TAPS-1:0]         slice_80,
  output logic                    slice_first_80,
  output logic                    slice_last_80,
  output logic                    busy_80
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q [TAPS];
  logic [WIDTH-1:0] word_d [TAPS];
  logic             at_last;
  logic             load;
  logic             shift;

  assign at_last = (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_80 = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      word_d[k] = word_q[k];
    end

    case (state_q)
      StIdle: begin
        in_ready_80 = 1'b1;
        if (in_valid_80) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (slice_ready_80) begin
          if (!at_last) begin
            shift = 1'b1;
            cnt_d = cnt_q + CntW'(1);
          end else begin
            // Sign slice consumed: take the next frame now for zero-bubble streaming.
            in_ready_80 = 1'b1;
            if (in_valid_80) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (rst_80) begin
      in_ready_80 = 1'b0;
      load        = 1'b0;
    end

    if (load) begin
      cnt_d = '0;
    end
    for (int k = 0; k < TAPS; k++) begin
      if (load) begin
        word_d[k] = in_data_80[k*WIDTH +: WIDTH];
      end else if (shift) begin
        word_d[k] = word_q[k] >> 1;
      end
    end
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int k = 0; k < TAPS; k++) begin
        word_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < TAPS; k++) begin
        word_q[k] <= word_d[k];
      end
    end
  end

  // All outputs derive from registers only; slice is masked so IDLE shows zero.
  always_comb begin
    busy_80        = (state_q == StShift);
    slice_valid_80 = busy_80;
    slice_first_80 = busy_80 && (cnt_q == '0);
    slice_last_80  = busy_80 && at_last;
    for (int k = 0; k < TAPS; k++) begin
      slice_80[k] = busy_80 & word_q[k][0];
    end
  end

endmodule

// File: tb/tb_da_bit_slicer.sv
// Self-checking bench for da_bit_slicer: table-driven frames plus hand-written corner
// sequences, with a scoreboard queue of expected slices popped on each consumed slice.
module tb_da_bit_slicer;
  localparam int TAPS  = 4;
  localparam int WIDTH = 4;

  logic                  clk_80 = 1'b0;
  logic                  rst_80;
  logic                  in_valid_80;
  logic                  in_ready_80;
  logic [TAPS*WIDTH-1:0] in_data_80;
  logic                  slice_valid_80;
  logic                  slice_ready_80;
  logic [TAPS-1:0]       slice_80;
  logic                  slice_first_80;
  logic                  slice_last_80;
  logic                  busy_80;

  da_bit_slicer #(.TAPS(TAPS), .WIDTH(WIDTH)) dut (
    .clk_80         (clk_80),
    .rst_80         (rst_80),
    .in_valid_80    (in_valid_80),
    .in_ready_80    (in_ready_80),
    .in_data_80     (in_data_80),
    .slice_valid_80 (slice_valid_80),
    .slice_ready_80 (slice_ready_80),
    .slice_80       (slice_80),
    .slice_first_80 (slice_first_80),
    .slice_last_80  (slice_last_80),
    .busy_80        (busy_80)
  );

  always #5 clk_80 = ~clk_80;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_80) cyc++;

  typedef struct {
    logic [TAPS*WIDTH-1:0] data;
    logic [TAPS*WIDTH-1:0] slices;  // slice b at [b*TAPS +: TAPS]
  } vec_t;

  typedef logic [TAPS+1:0] sb_t;  // {slice, first, last}
  sb_t sb_q[$];

  bit                    tbl_mode = 1'b0;
  logic [TAPS*WIDTH-1:0] tbl_exp  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TAPS-1:0] model_slice(input logic [TAPS*WIDTH-1:0] d, input int b);
    logic [TAPS-1:0] s;
    for (int k = 0; k < TAPS; k++) s[k] = d[k*WIDTH + b];
    return s;
  endfunction

  // Scoreboard: pop on consumed slice, push a frame's worth on acceptance.
  always @(negedge clk_80) begin
    if (!rst_80) begin
      if (slice_valid_80 && slice_ready_80) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_slice: got %0h expected none", slice_80);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("slice", 32'({slice_80, slice_first_80, slice_last_80}), 32'(e));
        end
      end
      if (in_valid_80 && in_ready_80) begin
        for (int b = 0; b < WIDTH; b++) begin
          logic [TAPS-1:0] s;
          s = tbl_mode ? tbl_exp[b*TAPS +: TAPS] : model_slice(in_data_80, b);
          sb_q.push_back({s, b == 0, b == WIDTH - 1});
        end
      end
    end
  end

  task automatic send(input logic [TAPS*WIDTH-1:0] d, input bit hold);
    in_data_80  = d;
    in_valid_80 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_80);
      if (in_ready_80) begin
        @(posedge clk_80);
        #1;
        if (!hold) begin
          in_valid_80 = 1'b0;
          in_data_80  = TAPS*WIDTH'($urandom);
        end
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no in_ready expected acceptance of %0h", d);
    in_valid_80 = 1'b0;
  endtask

  task automatic wait_idle(input bit churn, output int end_cyc);
    end_cyc = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_80);
      if (!busy_80) begin
        end_cyc = cyc;
        return;
      end
      @(posedge clk_80);
      #1;
      if (churn) in_data_80 = TAPS*WIDTH'($urandom);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy expected idle within 100 cycles");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  vec_t tbl[5];
  int   t0, t1;

  initial begin
    tbl[0] = '{data: 16'h6F5B, slices: 16'h5ED7};
    tbl[1] = '{data: 16'hFFFF, slices: 16'hFFFF};
    tbl[2] = '{data: 16'h0001, slices: 16'h0001};
    tbl[3] = '{data: 16'h8421, slices: 16'h8421};
    tbl[4] = '{data: 16'h1234, slices: 16'h016A};

    // Reset held with a pending frame.
    rst_80         = 1'b1;
    in_valid_80    = 1'b1;
    in_data_80     = 16'h6F5B;
    slice_ready_80 = 1'b1;
    repeat (2) @(posedge clk_80);
    #1;
    check("rst_in_ready", 32'(in_ready_80), 32'd0);
    check("rst_slice_valid", 32'(slice_valid_80), 32'd0);
    check("rst_slice", 32'(slice_80), 32'd0);
    check("rst_busy", 32'(busy_80), 32'd0);
    check("rst_flags", 32'({slice_first_80, slice_last_80}), 32'd0);
    rst_80      = 1'b0;
    in_valid_80 = 1'b0;
    @(negedge clk_80);
    check("post_rst_in_ready", 32'(in_ready_80), 32'd1);
    check("post_rst_slice_valid", 32'(slice_valid_80), 32'd0);
    @(posedge clk_80);
    #1;

    // Table frames with in_data churning throughout SHIFT.
    tbl_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tbl_exp = tbl[i].slices;
      send(tbl[i].data, 1'b0);
      t0 = cyc;
      wait_idle(1'b1, t1);
      check("frame_cycles", 32'(t1 - t0), 32'd4);
      check("frame_drained", 32'(sb_q.size()), 32'd0);
      check("idle_in_ready", 32'(in_ready_80), 32'd1);
      check("idle_slice_valid", 32'(slice_valid_80), 32'd0);
    end
    tbl_mode = 1'b0;

    // Back-to-back: second frame accepted on the sign slice with no bubble.
    send(16'h6F5B, 1'b1);
    t0 = cyc;
    send(16'hFFFF, 1'b0);
    check("b2b_accept_cycle", 32'(cyc - t0), 32'd4);
    wait_idle(1'b0, t1);
    check("b2b_cycles", 32'(t1 - t0), 32'd8);
    check("b2b_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure on slice 2 for three cycles.
    send(16'h6F5B, 1'b0);
    t0 = cyc;
    @(posedge clk_80);
    #1;
    slice_ready_80 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_80);
      check("stall_slice", 32'({slice_valid_80, slice_80, slice_first_80, slice_last_80}),
            32'({1'b1, 4'b1101, 1'b0, 1'b0}));
      @(posedge clk_80);
      #1;
    end
    slice_ready_80 = 1'b1;
    wait_idle(1'b0, t1);
    check("stall_cycles", 32'(t1 - t0), 32'd7);
    check("stall_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-frame after slice 2 is consumed.
    send(16'h6F5B, 1'b0);
    repeat (2) begin
      @(posedge clk_80);
      #1;
    end
    rst_80 = 1'b1;
    @(posedge clk_80);
    #1;
    check("abort_slice_valid", 32'(slice_valid_80), 32'd0);
    check("abort_busy", 32'(busy_80), 32'd0);
    check("abort_slice", 32'(slice_80), 32'd0);
    sb_q.delete();
    rst_80 = 1'b0;
    tbl_mode = 1'b1;
    tbl_exp  = 16'h0001;
    send(16'h0001, 1'b0);
    #3;
    check("restart_first", 32'({slice_valid_80, slice_first_80, slice_80}),
          32'({1'b1, 1'b1, 4'b0001}));
    wait_idle(1'b0, t1);
    check("restart_drained", 32'(sb_q.size()), 32'd0);
    tbl_mode = 1'b0;

    // Random streaming with random backpressure, checked against the transpose model.
    in_valid_80 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_data_80     = TAPS*WIDTH'($urandom);
      slice_ready_80 = 1'($urandom_range(0, 3) != 0);
      @(posedge clk_80);
      #1;
    end
    in_valid_80    = 1'b0;
    slice_ready_80 = 1'b1;
    wait_idle(1'b0, t1);
    check("random_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
